// File: rtl/ref_pingpong_bank.sv
// Double-buffered reference-pixel bank: one bank fills from the fetch side while the PE array
// reads the other; banks exchange by handshake. Define REF_PINGPONG_PARITY_EN for lane parity.
module ref_pingpong_bank #(
  parameter int unsigned PIXEL  = 8,
  parameter int unsigned LANES  = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beg_en,
  input  logic                   wr_valid,
  input  logic [LANES*PIXEL-1:0] ref_in,
  output logic                   wr_ready,
  output logic                   fill_done,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      address,
  output logic [LANES*PIXEL-1:0] ref_ou,
  output logic                   rd_valid,
  input  logic                   rd_done,
  output logic                   swap,
  output logic                   bank_sel,
`ifdef REF_PINGPONG_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   rd_bank_valid
);

  localparam int unsigned RowW = LANES * PIXEL;
`ifdef REF_PINGPONG_PARITY_EN
  localparam int unsigned MemW = RowW + LANES;
`else
  localparam int unsigned MemW = RowW;
`endif
  localparam int unsigned IdxW = $clog2(2 * DEPTH);

  localparam logic [ADDR_W:0]   DepthCmp = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(DEPTH - 1);
  localparam logic [IdxW-1:0]   DepthIdx = IdxW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              bank_sel_q, bank_sel_d;
  logic              rbv_q, rbv_d;
  logic              pending_q, pending_d;
  logic              wr_ready_q, wr_ready_d;
  logic              fill_done_q, fill_done_d;
  logic              swap_q, swap_d;
  logic              rd_valid_q, rd_valid_d;
  logic [RowW-1:0]   ref_ou_q, ref_ou_d;
`ifdef REF_PINGPONG_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  logic [MemW-1:0] mem [2*DEPTH];

  logic            wr_en;
  logic [IdxW-1:0] wr_idx;
  logic [MemW-1:0] wr_word;
  logic            addr_ok;
  logic            rd_hit;
  logic [IdxW-1:0] rd_idx;
  logic [MemW-1:0] rd_word;

`ifdef REF_PINGPONG_PARITY_EN
  // Even parity per lane: stored bit makes lane plus parity have an even count of ones.
  function automatic logic [LANES-1:0] lane_parity(input logic [RowW-1:0] row);
    logic [LANES-1:0] p;
    p = '0;
    for (int l = 0; l < LANES; l++) begin
      p[l] = ^row[l*PIXEL +: PIXEL];
    end
    return p;
  endfunction
`endif

  // Fill FSM and bank-exchange handshake.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bank_sel_d  = bank_sel_q;
    rbv_d       = rbv_q;
    fill_done_d = 1'b0;
    swap_d      = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (beg_en) begin
          state_d = StFill;
          ptr_d   = '0;
        end
      end
      StFill: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          if (ptr_q == LastPtr) begin
            state_d     = StFull;
            fill_done_d = 1'b1;
            ptr_d       = '0;
          end
        end
      end
      StFull: begin
        if (!rbv_q || pending_q || rd_done) begin
          state_d    = StIdle;
          bank_sel_d = ~bank_sel_q;
          rbv_d      = 1'b1;
          swap_d     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    pending_d = pending_q;
    if (swap_d) begin
      pending_d = 1'b0;
    end else if (rd_done && rbv_q) begin
      pending_d = 1'b1;
    end

    wr_ready_d = (state_d == StFill);
  end

  // Fill bank is always the one not being read.
  always_comb begin
    wr_idx = (bank_sel_q ? '0 : DepthIdx) + IdxW'(ptr_q);
`ifdef REF_PINGPONG_PARITY_EN
    wr_word = {lane_parity(ref_in), ref_in};
`else
    wr_word = ref_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_word;
    end
  end

  // Read path: out-of-range addresses are clamped to a safe index and reported invalid.
  always_comb begin
    addr_ok    = ({1'b0, address} < DepthCmp);
    rd_idx     = addr_ok ? ((bank_sel_q ? DepthIdx : '0) + IdxW'(address)) : '0;
    rd_word    = mem[rd_idx];
    rd_hit     = rd_en && rbv_q && addr_ok;
    rd_valid_d = rd_hit;
    ref_ou_d   = ref_ou_q;
    if (rd_en) begin
      ref_ou_d = rd_hit ? rd_word[RowW-1:0] : '0;
    end
`ifdef REF_PINGPONG_PARITY_EN
    parity_err_d = rd_hit && (lane_parity(rd_word[RowW-1:0]) != rd_word[MemW-1:RowW]);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      bank_sel_q   <= 1'b0;
      rbv_q        <= 1'b0;
      pending_q    <= 1'b0;
      wr_ready_q   <= 1'b0;
      fill_done_q  <= 1'b0;
      swap_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      ref_ou_q     <= '0;
`ifdef REF_PINGPONG_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      bank_sel_q   <= bank_sel_d;
      rbv_q        <= rbv_d;
      pending_q    <= pending_d;
      wr_ready_q   <= wr_ready_d;
      fill_done_q  <= fill_done_d;
      swap_q       <= swap_d;
      rd_valid_q   <= rd_valid_d;
      ref_ou_q     <= ref_ou_d;
`ifdef REF_PINGPONG_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign wr_ready      = wr_ready_q;
  assign fill_done     = fill_done_q;
  assign swap          = swap_q;
  assign bank_sel      = bank_sel_q;
  assign rd_bank_valid = rbv_q;
  assign rd_valid      = rd_valid_q;
  assign ref_ou        = ref_ou_q;
`ifdef REF_PINGPONG_PARITY_EN
  assign parity_err    = parity_err_q;
`endif

endmodule

// File: tb/tb_ref_pingpong_bank.sv
// Bench for ref_pingpong_bank: scoreboarded reads, fill/swap handshake, overlapped refill,
// depth boundary on a DEPTH=100 instance and asynchronous reset in the middle of a fill.
module tb_ref_pingpong_bank;

  logic        clk;
  logic        rst;
  logic        beg_en;
  logic        wr_valid;
  logic [63:0] ref_in;
  logic        rd_en;
  logic [6:0]  address;
  logic        rd_done;

  logic        wr_ready, fill_done, rd_valid, swap, bank_sel, rd_bank_valid;
  logic [63:0] ref_ou;
  logic        wr_ready2, fill_done2, rd_valid2, swap2, bank_sel2, rd_bank_valid2;
  logic [63:0] ref_ou2;
`ifdef REF_PINGPONG_PARITY_EN
  logic        parity_err, parity_err2;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ref_pingpong_bank #(.PIXEL(8), .LANES(8), .DEPTH(128), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .beg_en(beg_en), .wr_valid(wr_valid), .ref_in(ref_in),
    .wr_ready(wr_ready), .fill_done(fill_done), .rd_en(rd_en), .address(address),
    .ref_ou(ref_ou), .rd_valid(rd_valid), .rd_done(rd_done), .swap(swap),
    .bank_sel(bank_sel),
`ifdef REF_PINGPONG_PARITY_EN
    .parity_err(parity_err),
`endif
    .rd_bank_valid(rd_bank_valid)
  );

  ref_pingpong_bank #(.PIXEL(8), .LANES(8), .DEPTH(100), .ADDR_W(7)) dut2 (
    .clk(clk), .rst(rst), .beg_en(beg_en), .wr_valid(wr_valid), .ref_in(ref_in),
    .wr_ready(wr_ready2), .fill_done(fill_done2), .rd_en(rd_en), .address(address),
    .ref_ou(ref_ou2), .rd_valid(rd_valid2), .rd_done(rd_done), .swap(swap2),
    .bank_sel(bank_sel2),
`ifdef REF_PINGPONG_PARITY_EN
    .parity_err(parity_err2),
`endif
    .rd_bank_valid(rd_bank_valid2)
  );

  typedef struct packed {
    logic        v;
    logic [63:0] d;
    logic        p;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mdl [256];
  logic        mdl_sel;
  logic        mdl_rbv;
  logic [63:0] mdl_ref;
  int          corrupt_row;
  int          checks;
  int          errors;
  int          last_seen;
  int          last_fd;

  function automatic logic [63:0] pat(input int kind, input int i);
    logic [7:0] b;
    b = 8'(i);
    case (kind)
      0:       return {8{b}};
      1:       return (i < 128) ? {8{8'hA5}} : {8{8'h5A}};
      2:       return {8{8'h3C}};
      default: return {8{b ^ 8'h0F}};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: push the expected read result for the current drive, then pop and compare.
  task automatic cycle();
    exp_t e;
    exp_t g;
    e.v = rd_en && mdl_rbv;
    e.d = rd_en ? (e.v ? mdl[{mdl_sel, address}] : 64'h0) : mdl_ref;
    e.p = e.v && mdl_sel && (int'(address) == corrupt_row);
    mdl_ref = e.d;
    exp_q.push_back(e);
    tick();
    g = exp_q.pop_front();
    checks++;
    if (rd_valid !== g.v) begin
      errors++;
      $display("FAIL rd_valid t=%0t got %b want %b", $time, rd_valid, g.v);
    end
    checks++;
    if (ref_ou !== g.d) begin
      errors++;
      $display("FAIL ref_ou t=%0t got %h want %h", $time, ref_ou, g.d);
    end
`ifdef REF_PINGPONG_PARITY_EN
    checks++;
    if (parity_err !== g.p) begin
      errors++;
      $display("FAIL parity_err t=%0t got %b want %b", $time, parity_err, g.p);
    end
`endif
  endtask

  task automatic expect_swap(input logic exp);
    checks++;
    if (swap !== exp) begin
      errors++;
      $display("FAIL swap t=%0t got %b want %b", $time, swap, exp);
    end
    if (exp) begin
      mdl_sel = ~mdl_sel;
      mdl_rbv = 1'b1;
    end
    checks++;
    if (bank_sel !== mdl_sel || rd_bank_valid !== mdl_rbv) begin
      errors++;
      $display("FAIL bank_state t=%0t got sel=%b rbv=%b want sel=%b rbv=%b",
               $time, bank_sel, rd_bank_valid, mdl_sel, mdl_rbv);
    end
  endtask

  task automatic fill(input int ncyc, input int kind, input bit rd);
    int   acc;
    logic exp_rdy;
    acc = 0;
    last_seen = 0;
    last_fd = 0;
    beg_en = 1'b1;
    cycle();
    beg_en = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      exp_rdy  = (acc < 128);
      wr_valid = 1'b1;
      ref_in   = pat(kind, i);
      if (rd) begin
        rd_en   = 1'b1;
        address = 7'(i);
      end
      checks++;
      if (wr_ready !== exp_rdy) begin
        errors++;
        $display("FAIL wr_ready row=%0d got %b want %b", i, wr_ready, exp_rdy);
      end
      if (wr_ready === 1'b1) last_seen++;
      if (exp_rdy) begin
        mdl[{~mdl_sel, 7'(acc)}] = ref_in;
        acc++;
      end
      cycle();
      checks++;
      if (fill_done !== (exp_rdy && acc == 128)) begin
        errors++;
        $display("FAIL fill_done row=%0d got %b want %b", i, fill_done, exp_rdy && acc == 128);
      end
      checks++;
      if (swap !== 1'b0) begin
        errors++;
        $display("FAIL swap_in_fill row=%0d got %b want 0", i, swap);
      end
      if (fill_done === 1'b1) last_fd++;
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic read_list(input int n, input int a0, input int a1, input int a2, input int a3);
    int a [4];
    a = '{a0, a1, a2, a3};
    for (int k = 0; k < n; k++) begin
      rd_en   = 1'b1;
      address = 7'(a[k]);
      cycle();
    end
    rd_en = 1'b0;
    cycle();
  endtask

  task automatic check_reset_outputs();
    checks++;
    if ({bank_sel, rd_bank_valid, wr_ready, fill_done, swap, rd_valid} !== 6'b0 ||
        ref_ou !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs got sel=%b rbv=%b rdy=%b fd=%b sw=%b rv=%b ou=%h want all 0",
               bank_sel, rd_bank_valid, wr_ready, fill_done, swap, rd_valid, ref_ou);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    beg_en = 1'b0; wr_valid = 1'b0; ref_in = '0; rd_en = 1'b0; address = '0; rd_done = 1'b0;
    mdl_sel = 1'b0; mdl_rbv = 1'b0; mdl_ref = '0; corrupt_row = -1;
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();
    // Reads with no valid bank return zero.
    rd_en = 1'b1; address = 7'd5;
    cycle();
    address = 7'd127;
    cycle();
    rd_en = 1'b0;
    cycle();
  endtask

  task automatic test_first_fill();
    fill(128, 0, 1'b0);
    cycle();
    expect_swap(1'b1);
    checks++;
    if (fill_done !== 1'b0) begin
      errors++;
      $display("FAIL fill_done_with_swap got %b want 0", fill_done);
    end
    cycle();
    expect_swap(1'b0);
    checks++;
    if (bank_sel2 !== 1'b1 || rd_bank_valid2 !== 1'b1) begin
      errors++;
      $display("FAIL dut2_swap got sel=%b rbv=%b want 1 1", bank_sel2, rd_bank_valid2);
    end
  endtask

  task automatic test_read_rows();
    read_list(4, 0, 1, 2, 3);
    read_list(3, 4, 5, 8, 0);
  endtask

  task automatic test_depth_boundary();
    int a [3];
    a = '{99, 100, 127};
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b;
      b = 8'(a[k]);
      rd_en = 1'b1;
      address = 7'(a[k]);
      cycle();
      checks++;
      if (rd_valid2 !== (a[k] < 100) || ref_ou2 !== ((a[k] < 100) ? {8{b}} : 64'h0)) begin
        errors++;
        $display("FAIL depth100_read addr=%0d got v=%b d=%h", a[k], rd_valid2, ref_ou2);
      end
    end
    rd_en = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    fill(130, 1, 1'b1);
    checks++;
    if (last_seen != 128 || last_fd != 1) begin
      errors++;
      $display("FAIL accept_count got rows=%0d pulses=%0d want 128 1", last_seen, last_fd);
    end
    repeat (3) begin
      cycle();
      expect_swap(1'b0);
    end
    // Read issued in the swap cycle still sees the old bank.
    rd_done = 1'b1; rd_en = 1'b1; address = 7'd3;
    cycle();
    rd_done = 1'b0; rd_en = 1'b0;
    expect_swap(1'b1);
    cycle();
    expect_swap(1'b0);
    read_list(3, 0, 1, 127, 0);
  endtask

  task automatic test_pending();
    rd_done = 1'b1;
    cycle();
    rd_done = 1'b0;
    expect_swap(1'b0);
    fill(128, 2, 1'b0);
    cycle();
    expect_swap(1'b1);
    read_list(2, 0, 64, 0, 0);
  endtask

  task automatic test_reset_mid_fill();
    fill(60, 3, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    mdl_sel = 1'b0; mdl_rbv = 1'b0; mdl_ref = '0;
    tick();
    tick();
    rst = 1'b0;
    fill(128, 3, 1'b0);
    cycle();
    expect_swap(1'b1);
    read_list(4, 0, 59, 60, 127);
  endtask

`ifdef REF_PINGPONG_PARITY_EN
  task automatic test_parity();
    dut.mem[128+5][0] = ~dut.mem[128+5][0];
    mdl[{1'b1, 7'd5}][0] = ~mdl[{1'b1, 7'd5}][0];
    corrupt_row = 5;
    read_list(2, 5, 6, 0, 0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_fill();
    test_read_rows();
    test_depth_boundary();
    test_back_to_back();
    test_pending();
    test_reset_mid_fill();
`ifdef REF_PINGPONG_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
